// File: rtl/dmem_access_arbiter_if.sv
// Bundle of host, core and memory-side signals around the data memory arbiter.
// The slave modport is the arbiter's view; master is everything around it.
interface dmem_access_arbiter_if #(
    parameter int CORE_COUNT = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 48
);
    logic                             host_sel;
    logic                             host_req;
    logic                             host_we;
    logic [ADDR_WIDTH-1:0]            host_addr;
    logic [DATA_WIDTH-1:0]            host_wdata;
    logic                             host_gnt;
    logic                             host_rvalid;
    logic [CORE_COUNT-1:0]            core_req;
    logic [CORE_COUNT-1:0]            core_we;
    logic [CORE_COUNT*ADDR_WIDTH-1:0] core_addr;
    logic [CORE_COUNT*DATA_WIDTH-1:0] core_wdata;
    logic [CORE_COUNT-1:0]            core_gnt;
    logic [CORE_COUNT-1:0]            core_rvalid;
    logic [DATA_WIDTH-1:0]            rdata;
    logic [ADDR_WIDTH-1:0]            mem_addr;
    logic [DATA_WIDTH-1:0]            mem_wdata;
    logic                             mem_wren;
    logic [DATA_WIDTH-1:0]            mem_q;
    logic                             core_mode;

    modport slave (
        input  host_sel, host_req, host_we, host_addr, host_wdata,
        input  core_req, core_we, core_addr, core_wdata, mem_q,
        output host_gnt, host_rvalid, core_gnt, core_rvalid, rdata,
        output mem_addr, mem_wdata, mem_wren, core_mode
    );

    modport master (
        output host_sel, host_req, host_we, host_addr, host_wdata,
        output core_req, core_we, core_addr, core_wdata, mem_q,
        input  host_gnt, host_rvalid, core_gnt, core_rvalid, rdata,
        input  mem_addr, mem_wdata, mem_wren, core_mode
    );
endinterface

// File: rtl/dmem_access_arbiter.sv
// Single-port data memory arbiter: host ownership or round-robin core access,
// with read-return tracking and a drain phase on every ownership change.
module dmem_access_arbiter #(
    parameter int CORE_COUNT = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 48,
    parameter int RD_LATENCY = 1
) (
    input logic                  clk,
    input logic                  rstN,
    dmem_access_arbiter_if.slave bus
);
    localparam int PTR_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
    localparam int ID_W  = $clog2(CORE_COUNT + 1);
    localparam logic [ID_W-1:0] HOST_ID = ID_W'(CORE_COUNT);

    typedef enum logic [1:0] {S_HOST, S_DRAIN, S_CORE} state_t;

    state_t                         state, stateNxt;
    logic [PTR_W-1:0]               rrPtr, rrPtrNxt;
    logic [RD_LATENCY-1:0]          vldPipe;
    logic [RD_LATENCY-1:0][ID_W-1:0] idPipe;

    logic                  hostGnt, anyGnt, gntWe, inFlight;
    logic [CORE_COUNT-1:0] coreGnt, coreRvalid;
    logic [ID_W-1:0]       gntId;
    logic [ADDR_WIDTH-1:0] gntAddr;
    logic [DATA_WIDTH-1:0] gntWdata;

    // Grant and memory mux; everything is zero when nobody is granted.
    always_comb begin
        int   idx;
        logic found;
        idx      = 0;
        found    = 1'b0;
        hostGnt  = rstN && (state == S_HOST) && bus.host_req;
        coreGnt  = '0;
        rrPtrNxt = rrPtr;
        gntId    = HOST_ID;
        gntWe    = 1'b0;
        gntAddr  = '0;
        gntWdata = '0;
        if (hostGnt) begin
            gntWe    = bus.host_we;
            gntAddr  = bus.host_addr;
            gntWdata = bus.host_wdata;
        end else if (rstN && (state == S_CORE)) begin
            for (int off = 0; off < CORE_COUNT; off++) begin
                idx = int'(rrPtr) + off;
                if (idx >= CORE_COUNT) idx = idx - CORE_COUNT;
                if (!found && bus.core_req[idx]) begin
                    found        = 1'b1;
                    coreGnt[idx] = 1'b1;
                    rrPtrNxt     = (idx == CORE_COUNT - 1) ? '0 : PTR_W'(idx + 1);
                    gntId        = ID_W'(idx);
                    gntWe        = bus.core_we[idx];
                    gntAddr      = bus.core_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
                    gntWdata     = bus.core_wdata[idx*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
        anyGnt = hostGnt | found;
    end

    // The last pipe stage returns its data this cycle, so it does not hold the drain.
    always_comb begin
        inFlight = 1'b0;
        for (int i = 0; i < RD_LATENCY - 1; i++) inFlight = inFlight | vldPipe[i];
    end

    always_comb begin
        stateNxt = state;
        unique case (state)
            S_HOST:  if (!bus.host_sel) stateNxt = S_DRAIN;
            S_CORE:  if (bus.host_sel)  stateNxt = S_DRAIN;
            S_DRAIN: if (!inFlight)     stateNxt = bus.host_sel ? S_HOST : S_CORE;
            default: stateNxt = S_HOST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state   <= S_HOST;
            rrPtr   <= '0;
            vldPipe <= '0;
            idPipe  <= '0;
        end else begin
            state      <= stateNxt;
            rrPtr      <= rrPtrNxt;
            vldPipe[0] <= anyGnt & ~gntWe;
            idPipe[0]  <= gntId;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vldPipe[i] <= vldPipe[i-1];
                idPipe[i]  <= idPipe[i-1];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < CORE_COUNT; k++)
            coreRvalid[k] = rstN && vldPipe[RD_LATENCY-1] && (idPipe[RD_LATENCY-1] == ID_W'(k));
    end

    assign bus.host_rvalid = rstN && vldPipe[RD_LATENCY-1] && (idPipe[RD_LATENCY-1] == HOST_ID);
    assign bus.core_rvalid = coreRvalid;
    assign bus.host_gnt    = hostGnt;
    assign bus.core_gnt    = coreGnt;
    assign bus.mem_wren    = anyGnt & gntWe;
    assign bus.mem_addr    = gntAddr;
    assign bus.mem_wdata   = gntWdata;
    assign bus.rdata       = bus.mem_q;
    assign bus.core_mode   = rstN && (state == S_CORE);
endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Bench for dmem_access_arbiter: directed scenarios plus random traffic, every
// cycle compared against an ownership/round-robin/read-return reference model.
module tb_dmem_access_arbiter;
    localparam int CC = 4, AW = 12, DW = 48, RL = 1;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    dmem_access_arbiter_if #(.CORE_COUNT(CC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
    dmem_access_arbiter #(.CORE_COUNT(CC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RL))
        dut (.clk(clk), .rstN(rstN), .bus(bus));

    // Single-port synchronous memory, one cycle address-to-q.
    logic [DW-1:0] ram [1<<AW];
    always @(posedge clk) begin
        if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_q <= ram[bus.mem_addr];
    end

    typedef struct { int due; int who; logic [DW-1:0] data; } rd_t;
    int            mMode;   // 0 host owns, 1 draining, 2 cores own
    int            mPtr;
    int            cyc;
    logic [DW-1:0] refMem [1<<AW];
    rd_t           pend[$];
    int            checks = 0, errors = 0;
    logic          lastHg;
    int            lastK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: predict this cycle's outputs, compare, then advance the model.
    task automatic step();
        logic hg, ewe, hrv, sel, busy, rvAny;
        logic [CC-1:0] cg, crv;
        logic [AW-1:0] ea;
        logic [DW-1:0] ew, ed;
        int k, c;
        #1;
        hg = rstN && mMode == 0 && bus.host_req;
        k = -1;
        if (rstN && mMode == 2)
            for (int o = 0; o < CC; o++) begin
                c = (mPtr + o) % CC;
                if (k < 0 && bus.core_req[c]) k = c;
            end
        cg = '0;
        if (k >= 0) cg[k] = 1'b1;
        ewe = 1'b0; ea = '0; ew = '0;
        if (hg) begin
            ewe = bus.host_we; ea = bus.host_addr; ew = bus.host_wdata;
        end else if (k >= 0) begin
            ewe = bus.core_we[k]; ea = bus.core_addr[k*AW +: AW]; ew = bus.core_wdata[k*DW +: DW];
        end
        hrv = 1'b0; crv = '0; ed = '0;
        foreach (pend[i])
            if (rstN && pend[i].due == cyc) begin
                if (pend[i].who < 0) hrv = 1'b1; else crv[pend[i].who] = 1'b1;
                ed = pend[i].data;
            end
        rvAny = hrv || (crv != '0);
        check("host_gnt", bus.host_gnt, hg);
        check("core_gnt", bus.core_gnt, cg);
        check("mem_wren", bus.mem_wren, ewe);
        check("mem_addr", bus.mem_addr, ea);
        check("mem_wdata", bus.mem_wdata, ew);
        check("host_rvalid", bus.host_rvalid, hrv);
        check("core_rvalid", bus.core_rvalid, crv);
        check("core_mode", bus.core_mode, rstN && mMode == 2);
        if (rvAny) check("rdata", bus.rdata, ed);
        sel = bus.host_sel;
        lastHg = hg; lastK = k;
        @(posedge clk);
        if (!rstN) begin
            mMode = 0; mPtr = 0; pend.delete();
        end else begin
            busy = 1'b0;
            foreach (pend[i]) if (pend[i].due > cyc) busy = 1'b1;
            if (hg || k >= 0) begin
                if (ewe) refMem[ea] = ew;
                else pend.push_back('{cyc + RL, hg ? -1 : k, refMem[ea]});
            end
            if (k >= 0) mPtr = (k + 1) % CC;
            case (mMode)
                0: if (!sel) mMode = 1;
                2: if (sel)  mMode = 1;
                default: if (!busy) mMode = sel ? 0 : 2;
            endcase
            while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic setCore(input int c, input logic req, input logic we, input int addr,
                           input logic [DW-1:0] d);
        bus.core_req[c]          = req;
        bus.core_we[c]           = we;
        bus.core_addr[c*AW +: AW] = AW'(addr);
        bus.core_wdata[c*DW +: DW] = d;
    endtask

    task automatic gotoMode(input logic sel, input int want);
        bus.host_sel = sel;
        for (int i = 0; i < 8 && mMode != want; i++) step();
        check("mode_reached", bus.core_mode, want == 2);
    endtask

    logic [CC-1:0] seq [5];

    initial begin
        cyc = 0; mMode = 0; mPtr = 0;
        rstN = 1'b0;
        bus.host_sel = 1'b1; bus.host_req = 1'b1; bus.host_we = 1'b1;
        bus.host_addr = '0; bus.host_wdata = '0;
        bus.core_req = '1; bus.core_we = '0; bus.core_addr = '0; bus.core_wdata = '0;
        @(negedge clk);
        step(); step();
        rstN = 1'b1; bus.core_req = '0; bus.host_req = 1'b0;

        // Fill the address range used below so every read has known data.
        for (int a = 0; a < 16; a++) begin
            bus.host_req = 1'b1; bus.host_we = 1'b1;
            bus.host_addr = AW'(a); bus.host_wdata = DW'(a * 32'h1111 + 7);
            step();
        end
        bus.host_addr = 12'd5; bus.host_wdata = 48'hABC; step();
        bus.host_we = 1'b0; step();
        bus.host_req = 1'b0;
        check("host_rd_rvalid", bus.host_rvalid, 1'b1);
        check("host_rd_data", bus.rdata, 48'hABC);
        step();

        // Four cores holding reads: strict rotation from core0.
        gotoMode(1'b0, 2);
        for (int c = 0; c < CC; c++) setCore(c, 1'b1, 1'b0, c, '0);
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            #1 check("rr_all", bus.core_gnt, seq[i]);
            step();
        end
        bus.core_req = 4'b0010; step();
        bus.core_req = 4'b1001;
        #1 check("rr_skip_3", bus.core_gnt, 4'b1000);
        step();
        bus.core_req = 4'b0001;
        #1 check("rr_skip_0", bus.core_gnt, 4'b0001);
        step();

        // Write then read of the same address on consecutive cycles.
        bus.core_req = '0;
        setCore(1, 1'b1, 1'b1, 9, 48'h123); step();
        setCore(1, 1'b0, 1'b0, 0, '0);
        setCore(2, 1'b1, 1'b0, 9, '0); step();
        setCore(2, 1'b0, 1'b0, 0, '0);
        check("raw_rvalid", bus.core_rvalid, 4'b0100);
        check("raw_rdata", bus.rdata, 48'h123);
        step();

        // Ownership flip with a core read in flight.
        setCore(2, 1'b1, 1'b0, 2, '0);
        bus.host_sel = 1'b1; bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 12'd7;
        step();
        setCore(2, 1'b0, 1'b0, 0, '0);
        check("flip_rvalid", bus.core_rvalid, 4'b0100);
        #1 check("flip_no_hgnt", bus.host_gnt, 1'b0);
        check("flip_no_cgnt", bus.core_gnt, 4'b0000);
        step();
        #1 check("flip_hgnt", bus.host_gnt, 1'b1);
        step();
        bus.host_req = 1'b0; step();

        // Reset while core reads are in flight.
        gotoMode(1'b0, 2);
        for (int c = 0; c < CC; c++) setCore(c, 1'b1, 1'b0, c + 4, '0);
        step();
        rstN = 1'b0;
        #1 check("rst_rvalid", bus.core_rvalid, 4'b0000);
        step();
        rstN = 1'b1;
        #1 check("rst_mode", bus.core_mode, 1'b0);
        step();
        gotoMode(1'b0, 2);
        #1 check("rst_ptr", bus.core_gnt, 4'b0001);
        step();
        bus.core_req = '0;

        // Random traffic with ownership flips and occasional resets.
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < CC; c++)
                if (!bus.core_req[c] && $urandom_range(0, 2) == 0)
                    setCore(c, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                            DW'({$urandom(), $urandom()}));
            if (!bus.host_req && $urandom_range(0, 2) == 0) begin
                bus.host_req = 1'b1; bus.host_we = 1'($urandom_range(0, 1));
                bus.host_addr = AW'($urandom_range(0, 15));
                bus.host_wdata = DW'({$urandom(), $urandom()});
            end
            if ($urandom_range(0, 19) == 0) bus.host_sel = ~bus.host_sel;
            rstN = ($urandom_range(0, 99) != 0);
            step();
            if (lastK >= 0) bus.core_req[lastK] = 1'b0;
            if (lastHg) bus.host_req = 1'b0;
        end
        rstN = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
